// File: rtl/mem_bus_arb.sv
// mem_bus_arb: two-master arbiter in front of the byte-wide memory sequencer.
// Master 0 is the CPU and master 1 is the debug/boot loader. The loader can hold
// the bus across back-to-back transactions with m1_lock, up to MAX_LOCK dones.
// Optional feature macro: ARB_RR_EN (round-robin tie-break instead of m0 > m1).
module mem_bus_arb #(
  parameter int unsigned RV       = 16,
  parameter int unsigned MAX_LOCK = 64,
  localparam int unsigned AW      = RV - RV/16
) (
  input  logic          clk,
  input  logic          reset,
  // master 0 (CPU)
  input  logic [1:0]    m0_rreq,
  input  logic [AW-1:0] m0_raddr,
  input  logic [1:0]    m0_wmask,
  input  logic [AW-1:0] m0_waddr,
  input  logic [RV-1:0] m0_wdata,
  output logic          m0_rdone,
  output logic          m0_wdone,
  // master 1 (loader)
  input  logic [1:0]    m1_rreq,
  input  logic [AW-1:0] m1_raddr,
  input  logic [1:0]    m1_wmask,
  input  logic [AW-1:0] m1_waddr,
  input  logic [RV-1:0] m1_wdata,
  output logic          m1_rdone,
  output logic          m1_wdone,
  input  logic          m1_lock,
  // sequencer side
  output logic [1:0]    s_rreq,
  output logic [AW-1:0] s_raddr,
  output logic [1:0]    s_wmask,
  output logic [AW-1:0] s_waddr,
  output logic [RV-1:0] s_wdata,
  input  logic          s_rdone,
  input  logic          s_wdone,
  input  logic [RV-1:0] s_rdata,
  output logic [RV-1:0] m_rdata,
  output logic [1:0]    gnt
);

  localparam int unsigned LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state;
  logic [LCW-1:0] lock_cnt;

  logic req0;
  logic req1;
  logic win_m1;
  logic fwd0;
  logic fwd1;
  logic sdone;

  assign req0  = (|m0_rreq) | (|m0_wmask);
  assign req1  = (|m1_rreq) | (|m1_wmask);
  assign sdone = s_rdone | s_wdone;

  // Only a BUSY state forwards; HOLD keeps gnt but presents an all-zero bubble.
  // Reset blanks the slave side and the done pulses in the reset cycle itself.
  assign fwd0 = (state == BUSY) && gnt[0] && !reset;
  assign fwd1 = (state == BUSY) && gnt[1] && !reset;

`ifdef ARB_RR_EN
  // rr_last names the master granted last from IDLE; the other one wins a tie.
  logic rr_last;

  // Winner selection in IDLE: round-robin on a tie.
  always_comb begin
    win_m1 = req1 && (!req0 || !rr_last);
  end
`else
  // Winner selection in IDLE: fixed priority, m0 beats m1.
  always_comb begin
    win_m1 = req1 && !req0;
  end
`endif

  // Arbitration FSM: grant, lock counter and (optionally) round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      lock_cnt <= '0;
`ifdef ARB_RR_EN
      // Reset to "m1 last" so that m0 takes the first tie.
      rr_last  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          lock_cnt <= '0;
          if (req0 || req1) begin
            state <= BUSY;
            gnt   <= win_m1 ? 2'b10 : 2'b01;
`ifdef ARB_RR_EN
            rr_last <= win_m1;
`endif
          end
        end
        BUSY: begin
          if (sdone) begin
            if (gnt[1] && m1_lock) begin
              state <= HOLD;
              if (lock_cnt != LOCK_MAX) begin
                lock_cnt <= lock_cnt + LCW'(1);
              end
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end
        end
        HOLD: begin
          if (req1 && (lock_cnt < LOCK_MAX)) begin
            state <= BUSY;
          end else begin
            state <= IDLE;
            gnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  // Request mux towards the sequencer, selected by the registered grant.
  always_comb begin
    s_rreq  = '0;
    s_raddr = '0;
    s_wmask = '0;
    s_waddr = '0;
    s_wdata = '0;
    if (fwd0) begin
      s_rreq  = m0_rreq;
      s_raddr = m0_raddr;
      s_wmask = m0_wmask;
      s_waddr = m0_waddr;
      s_wdata = m0_wdata;
    end else if (fwd1) begin
      s_rreq  = m1_rreq;
      s_raddr = m1_raddr;
      s_wmask = m1_wmask;
      s_waddr = m1_waddr;
      s_wdata = m1_wdata;
    end
  end

  // Done pulses route combinationally to the granted master only.
  always_comb begin
    m0_rdone = fwd0 && s_rdone;
    m0_wdone = fwd0 && s_wdone;
    m1_rdone = fwd1 && s_rdone;
    m1_wdone = fwd1 && s_wdone;
  end

  assign m_rdata = s_rdata;

endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: directed vector table plus hand-written multi-cycle sequences
// for mem_bus_arb (RV=16, MAX_LOCK=4). Expectations follow ARB_RR_EN if defined.
module tb_mem_bus_arb;

  localparam int RV = 16;
  localparam int AW = 15;

  localparam logic [AW-1:0] M0_RA = 15'h1234;
  localparam logic [AW-1:0] M0_WA = 15'h0aaa;
  localparam logic [RV-1:0] M0_WD = 16'h5a5a;
  localparam logic [AW-1:0] M1_RA = 15'h7001;
  localparam logic [AW-1:0] M1_WA = 15'h0155;
  localparam logic [RV-1:0] M1_WD = 16'hc3c3;
  localparam logic [RV-1:0] SRD   = 16'hbeef;
  localparam logic [1:0]    W     = 2'b11;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] m0_rreq, m0_wmask, m1_rreq, m1_wmask;
  logic [AW-1:0] m0_raddr, m0_waddr, m1_raddr, m1_waddr;
  logic [RV-1:0] m0_wdata, m1_wdata;
  logic m0_rdone, m0_wdone, m1_rdone, m1_wdone, m1_lock;
  logic [1:0] s_rreq, s_wmask, gnt;
  logic [AW-1:0] s_raddr, s_waddr;
  logic [RV-1:0] s_wdata, s_rdata, m_rdata;
  logic s_rdone, s_wdone;

  always #5 clk = ~clk;

  mem_bus_arb #(.RV(16), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .m0_rreq(m0_rreq), .m0_raddr(m0_raddr), .m0_wmask(m0_wmask),
    .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_rdone(m0_rdone), .m0_wdone(m0_wdone),
    .m1_rreq(m1_rreq), .m1_raddr(m1_raddr), .m1_wmask(m1_wmask),
    .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_rdone(m1_rdone), .m1_wdone(m1_wdone),
    .m1_lock(m1_lock),
    .s_rreq(s_rreq), .s_raddr(s_raddr), .s_wmask(s_wmask), .s_waddr(s_waddr),
    .s_wdata(s_wdata), .s_rdone(s_rdone), .s_wdone(s_wdone), .s_rdata(s_rdata),
    .m_rdata(m_rdata), .gnt(gnt)
  );

  // One clock of stimulus and the outputs expected during that clock.
  // fwd: 0 = slave side all zero, 1 = m0 forwarded, 2 = m1 forwarded.
  // done: {m1_wdone, m1_rdone, m0_wdone, m0_rdone}.
  typedef struct {
    string      name;
    logic       rst;
    logic [1:0] m0r, m0w, m1r, m1w;
    logic       lk, rd, wd;
    logic [1:0] gnt;
    logic [1:0] fwd;
    logic [3:0] done;
  } vec_t;

  vec_t vq[$];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input string nm, input logic rst,
                              input logic [1:0] m0r, input logic [1:0] m0w,
                              input logic [1:0] m1r, input logic [1:0] m1w,
                              input logic lk, input logic rd, input logic wd,
                              input logic [1:0] g, input logic [1:0] f, input logic [3:0] d);
    vec_t v;
    v.name = nm; v.rst = rst; v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w;
    v.lk = lk; v.rd = rd; v.wd = wd; v.gnt = g; v.fwd = f; v.done = d;
    return v;
  endfunction

  task automatic clear_inputs();
    reset = 1'b0; m0_rreq = '0; m0_wmask = '0; m1_rreq = '0; m1_wmask = '0;
    m1_lock = 1'b0; s_rdone = 1'b0; s_wdone = 1'b0;
  endtask

  // Inputs are applied just after posedge; outputs are checked at negedge.
  task automatic apply(input vec_t v);
    logic [1:0] e_rr, e_wm;
    logic [AW-1:0] e_ra, e_wa;
    logic [RV-1:0] e_wd;
    reset = v.rst; m0_rreq = v.m0r; m0_wmask = v.m0w; m1_rreq = v.m1r; m1_wmask = v.m1w;
    m1_lock = v.lk; s_rdone = v.rd; s_wdone = v.wd;
    e_rr = '0; e_wm = '0; e_ra = '0; e_wa = '0; e_wd = '0;
    if (v.fwd == 2'd1) begin
      e_rr = v.m0r; e_wm = v.m0w; e_ra = M0_RA; e_wa = M0_WA; e_wd = M0_WD;
    end else if (v.fwd == 2'd2) begin
      e_rr = v.m1r; e_wm = v.m1w; e_ra = M1_RA; e_wa = M1_WA; e_wd = M1_WD;
    end
    @(negedge clk);
    chk({v.name, ".gnt"},     32'(gnt),     32'(v.gnt));
    chk({v.name, ".s_rreq"},  32'(s_rreq),  32'(e_rr));
    chk({v.name, ".s_raddr"}, 32'(s_raddr), 32'(e_ra));
    chk({v.name, ".s_wmask"}, 32'(s_wmask), 32'(e_wm));
    chk({v.name, ".s_waddr"}, 32'(s_waddr), 32'(e_wa));
    chk({v.name, ".s_wdata"}, 32'(s_wdata), 32'(e_wd));
    chk({v.name, ".done"}, 32'({m1_wdone, m1_rdone, m0_wdone, m0_rdone}), 32'(v.done));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

`ifdef ARB_RR_EN
  localparam int NT = 4;
  logic [1:0] t2_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic       t2_m0  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
  localparam int NT = 2;
  logic [1:0] t2_exp [2] = '{2'b01, 2'b10};
  logic       t2_m0  [2] = '{1'b1, 1'b0};
`endif

  initial begin
    m0_raddr = M0_RA; m0_waddr = M0_WA; m0_wdata = M0_WD;
    m1_raddr = M1_RA; m1_waddr = M1_WA; m1_wdata = M1_WD;
    s_rdata  = SRD;
    clear_inputs();
    @(posedge clk); #1;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.s_wmask", 32'(s_wmask), 32'd0);
    chk("rst.s_rreq", 32'(s_rreq), 32'd0);
    chk("m_rdata", 32'(m_rdata), 32'(SRD));
    @(posedge clk); #1;

    //            name              rst m0r m0w m1r m1w lk rd wd gnt    fwd done
    vq.push_back(mk("t1_req",        0, W,  0,  0,  0,  0, 0, 0, 2'b00, 0, 4'b0000));
    vq.push_back(mk("t1_busy_a",     0, W,  0,  0,  0,  0, 0, 0, 2'b01, 1, 4'b0000));
    vq.push_back(mk("t1_busy_b",     0, W,  0,  0,  0,  0, 0, 0, 2'b01, 1, 4'b0000));
    vq.push_back(mk("t1_busy_c",     0, W,  0,  0,  0,  0, 0, 0, 2'b01, 1, 4'b0000));
    vq.push_back(mk("t1_done",       0, W,  0,  0,  0,  0, 1, 0, 2'b01, 1, 4'b0001));
    vq.push_back(mk("t1_bubble",     0, 0,  0,  0,  0,  0, 0, 0, 2'b00, 0, 4'b0000));
    vq.push_back(mk("t6_idle_rdone", 0, 0,  0,  0,  0,  0, 1, 0, 2'b00, 0, 4'b0000));
    vq.push_back(mk("t6_after",      0, 0,  0,  0,  0,  0, 0, 0, 2'b00, 0, 4'b0000));
    vq.push_back(mk("t3_m1_req",     0, 0,  0,  0,  W,  1, 0, 0, 2'b00, 0, 4'b0000));
    vq.push_back(mk("t3_busy1",      0, 0,  W,  0,  W,  1, 0, 0, 2'b10, 2, 4'b0000));
    vq.push_back(mk("t3_done1",      0, 0,  W,  0,  W,  1, 0, 1, 2'b10, 2, 4'b1000));
    vq.push_back(mk("t3_hold1",      0, 0,  W,  0,  W,  1, 0, 0, 2'b10, 0, 4'b0000));
    vq.push_back(mk("t3_busy2",      0, 0,  W,  0,  W,  1, 0, 0, 2'b10, 2, 4'b0000));
    vq.push_back(mk("t3_done2",      0, 0,  W,  0,  W,  1, 0, 1, 2'b10, 2, 4'b1000));
    vq.push_back(mk("t3_hold2",      0, 0,  W,  0,  W,  1, 0, 0, 2'b10, 0, 4'b0000));
    vq.push_back(mk("t3_done3",      0, 0,  W,  0,  W,  1, 0, 1, 2'b10, 2, 4'b1000));
    vq.push_back(mk("t3_hold3",      0, 0,  W,  0,  0,  0, 0, 0, 2'b10, 0, 4'b0000));
    vq.push_back(mk("t3_idle",       0, 0,  W,  0,  0,  0, 0, 0, 2'b00, 0, 4'b0000));
    vq.push_back(mk("t5_busy",       0, 0,  W,  0,  0,  0, 0, 0, 2'b01, 1, 4'b0000));
    vq.push_back(mk("t5_reset",      1, 0,  W,  0,  0,  0, 0, 1, 2'b01, 0, 4'b0000));
    vq.push_back(mk("t5_post",       0, 0,  W,  0,  0,  0, 0, 1, 2'b00, 0, 4'b0000));
    vq.push_back(mk("t5_regrant",    0, 0,  W,  0,  0,  0, 0, 1, 2'b01, 1, 4'b0010));
    vq.push_back(mk("t5_bubble",     0, 0,  0,  0,  0,  0, 0, 0, 2'b00, 0, 4'b0000));

    foreach (vq[i]) apply(vq[i]);

    // Test 2: simultaneous writes from both masters.
    do_reset();
    for (int t = 0; t < NT; t++) begin
      m0_wmask = t2_m0[t] ? W : 2'b00;
      m1_wmask = W;
      @(negedge clk);
      chk($sformatf("t2_idle%0d.gnt", t), 32'(gnt), 32'd0);
      @(posedge clk); #1;
      s_wdone = 1'b1;
      @(negedge clk);
      chk($sformatf("t2_win%0d.gnt", t), 32'(gnt), 32'(t2_exp[t]));
      chk($sformatf("t2_win%0d.m0_wdone", t), 32'(m0_wdone), 32'(t2_exp[t][0]));
      chk($sformatf("t2_win%0d.m1_wdone", t), 32'(m1_wdone), 32'(t2_exp[t][1]));
      @(posedge clk); #1;
      s_wdone = 1'b0;
    end
    clear_inputs();
    @(negedge clk);
    chk("t2_end.gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;

    // Test 4: lock held for MAX_LOCK=4 dones, then forced release to m0.
    do_reset();
    m1_wmask = W; m1_lock = 1'b1;
    @(negedge clk);
    chk("t4_idle.gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    m0_wmask = W;
    for (int k = 0; k < 4; k++) begin
      s_wdone = 1'b1;
      @(negedge clk);
      chk($sformatf("t4_busy%0d.gnt", k), 32'(gnt), 32'b10);
      chk($sformatf("t4_busy%0d.s_waddr", k), 32'(s_waddr), 32'(M1_WA));
      chk($sformatf("t4_busy%0d.m1_wdone", k), 32'(m1_wdone), 32'd1);
      chk($sformatf("t4_busy%0d.m0_wdone", k), 32'(m0_wdone), 32'd0);
      @(posedge clk); #1;
      s_wdone = (k == 1);
      @(negedge clk);
      chk($sformatf("t4_hold%0d.gnt", k), 32'(gnt), 32'b10);
      chk($sformatf("t4_hold%0d.s_wmask", k), 32'(s_wmask), 32'd0);
      chk($sformatf("t4_hold%0d.m1_wdone", k), 32'(m1_wdone), 32'd0);
      @(posedge clk); #1;
      s_wdone = 1'b0;
    end
    @(negedge clk);
    chk("t4_forced_idle.gnt", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_m0_gnt.gnt", 32'(gnt), 32'b01);
    chk("t4_m0_gnt.s_wdata", 32'(s_wdata), 32'(M0_WD));
    @(posedge clk); #1;
    s_wdone = 1'b1;
    @(negedge clk);
    chk("t4_m0_done.m0_wdone", 32'(m0_wdone), 32'd1);
    chk("t4_m0_done.m1_wdone", 32'(m1_wdone), 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
